// File: rtl/data_mem_ctrl.sv
// Data memory for the M stage: byte/half/word little-endian loads and stores,
// configurable depth and access latency with a stall handshake.
module data_mem_ctrl #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        SizeM,
  input  logic              UnsignedM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              MisalignedM
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [2:0] LAT   = 3'(LATENCY);

  logic [31:0]      mem_q [DEPTH];
  logic [2:0]       cnt_q, cnt_d;
  logic             req, misaligned, complete, wr_en;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      word, wr_data, rd_data;
  logic [3:0]       wr_be;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic             unused_addr;

  // Bits above the word index are ignored so addresses wrap modulo DEPTH.
  assign unused_addr = ^ALUResultM;

  always_comb begin
    req        = MemReadM | MemWriteM;
    idx        = ALUResultM[IDX_W+1:2];
    lane       = ALUResultM[1:0];
    misaligned = req & ((SizeM == 2'b11) |
                        ((SizeM == 2'b01) & lane[0]) |
                        ((SizeM == 2'b10) & (lane != 2'b00)));
    complete   = req & ~misaligned & (cnt_q == LAT);

    cnt_d = cnt_q;
    if (!req)            cnt_d = '0;
    else if (misaligned) cnt_d = cnt_q;
    else if (complete)   cnt_d = '0;
    else                 cnt_d = cnt_q + 3'd1;

    wr_en = rst_n & complete & MemWriteM;
    case (SizeM)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{WriteDataM[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = WriteDataM;
      end
    endcase

    word    = mem_q[idx];
    rd_byte = word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? word[31:16] : word[15:0];
    case (SizeM)
      2'b00:   rd_data = UnsignedM ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_data = UnsignedM ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_data = word;
    endcase

    // Store wins over load, so data is only driven on a pure-load completion.
    ReadDataM   = (rst_n & complete & ~MemWriteM) ? rd_data : '0;
    StallM      = rst_n & req & ~misaligned & ~complete;
    MisalignedM = rst_n & misaligned;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a zero-latency instance driven from a vector table
// and a three-cycle-latency instance driven by hand-written sequences.
module tb_data_mem_ctrl;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd0, wr0, uns0, rd3, wr3, uns3;
  logic [1:0]  size0, size3;
  logic [31:0] addr0, wd0, addr3, wd3;
  logic [31:0] rdata0, rdata3;
  logic        stall0, mis0, stall3, mis3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(64), .ADDR_W(32), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .MemReadM(rd0), .MemWriteM(wr0), .SizeM(size0),
    .UnsignedM(uns0), .ALUResultM(addr0), .WriteDataM(wd0),
    .ReadDataM(rdata0), .StallM(stall0), .MisalignedM(mis0)
  );

  data_mem_ctrl #(.DEPTH(64), .ADDR_W(32), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .MemReadM(rd3), .MemWriteM(wr3), .SizeM(size3),
    .UnsignedM(uns3), .ALUResultM(addr3), .WriteDataM(wd3),
    .ReadDataM(rdata3), .StallM(stall3), .MisalignedM(mis3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input string n, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic uns, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] er, input logic em);
    vec_t r;
    r.name = n; r.rd = rd; r.wr = wr; r.size = sz; r.uns = uns;
    r.addr = a; r.wdata = wd; r.exp_rd = er; r.exp_mis = em;
    return r;
  endfunction

  task automatic drive3(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    rd3 = rd; wr3 = wr; size3 = sz; uns3 = uns; addr3 = a; wd3 = wd;
  endtask

  // One complete access on the latency-3 instance: stall 1,1,1 then 0, data only in the last cycle.
  task automatic acc3(input string n, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_final);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive3(rd, wr, sz, uns, a, wd);
      #1;
      chk($sformatf("%s stall c%0d", n, c), {31'b0, stall3}, (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("%s rdata c%0d", n, c), rdata3, (c == 3) ? exp_final : 32'd0);
    end
  endtask

  task automatic idle3();
    @(negedge clk);
    drive3(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back(v("st w 0x00",      0, 1, 2'b10, 0, 32'h00, 32'hA1A2A3A4, 32'h0,        0));
    vecs.push_back(v("st w 0x04",      0, 1, 2'b10, 0, 32'h04, 32'h5A5A5A5A, 32'h0,        0));
    vecs.push_back(v("st w 0x1C",      0, 1, 2'b10, 0, 32'h1C, 32'h12345678, 32'h0,        0));
    vecs.push_back(v("ld w 0x00",      1, 0, 2'b10, 0, 32'h00, 32'h0,        32'hA1A2A3A4, 0));
    vecs.push_back(v("ld w 0x04",      1, 0, 2'b10, 0, 32'h04, 32'h0,        32'h5A5A5A5A, 0));
    vecs.push_back(v("ld w 0x1C",      1, 0, 2'b10, 0, 32'h1C, 32'h0,        32'h12345678, 0));
    vecs.push_back(v("st w 0x08 zero", 0, 1, 2'b10, 0, 32'h08, 32'h00000000, 32'h0,        0));
    vecs.push_back(v("st b 0x09",      0, 1, 2'b00, 0, 32'h09, 32'h12345680, 32'h0,        0));
    vecs.push_back(v("st h 0x0A",      0, 1, 2'b01, 0, 32'h0A, 32'hABCDBEEF, 32'h0,        0));
    vecs.push_back(v("ld w 0x08",      1, 0, 2'b10, 0, 32'h08, 32'h0,        32'hBEEF8000, 0));
    vecs.push_back(v("ld bs 0x09",     1, 0, 2'b00, 0, 32'h09, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(v("ld bu 0x09",     1, 0, 2'b00, 1, 32'h09, 32'h0,        32'h00000080, 0));
    vecs.push_back(v("ld hu 0x0A",     1, 0, 2'b01, 1, 32'h0A, 32'h0,        32'h0000BEEF, 0));
    vecs.push_back(v("ld hs 0x0A",     1, 0, 2'b01, 0, 32'h0A, 32'h0,        32'hFFFFBEEF, 0));
    vecs.push_back(v("ld hs 0x08",     1, 0, 2'b01, 0, 32'h08, 32'h0,        32'hFFFF8000, 0));
    vecs.push_back(v("ld bu 0x08",     1, 0, 2'b00, 1, 32'h08, 32'h0,        32'h00000000, 0));
    vecs.push_back(v("ld wu 0x00",     1, 0, 2'b10, 1, 32'h00, 32'h0,        32'hA1A2A3A4, 0));
    vecs.push_back(v("st b 0x1F",      0, 1, 2'b00, 0, 32'h1F, 32'hFFFFFF77, 32'h0,        0));
    vecs.push_back(v("ld bs 0x1F",     1, 0, 2'b00, 0, 32'h1F, 32'h0,        32'h00000077, 0));
    vecs.push_back(v("ld w 0x1C lane3",1, 0, 2'b10, 0, 32'h1C, 32'h0,        32'h77345678, 0));
    vecs.push_back(v("mis st w 0x02",  0, 1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(v("mis ld h 0x03",  1, 0, 2'b01, 0, 32'h03, 32'h0,        32'h0,        1));
    vecs.push_back(v("mis ld sz11",    1, 0, 2'b11, 0, 32'h00, 32'h0,        32'h0,        1));
    vecs.push_back(v("mis st h 0x01",  0, 1, 2'b01, 0, 32'h01, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(v("ld w 0x00 kept", 1, 0, 2'b10, 0, 32'h00, 32'h0,        32'hA1A2A3A4, 0));
    vecs.push_back(v("idle sz11",      0, 0, 2'b11, 0, 32'h03, 32'h0,        32'h0,        0));
    vecs.push_back(v("rd+wr 0x04",     1, 1, 2'b10, 0, 32'h04, 32'h0BADF00D, 32'h0,        0));
    vecs.push_back(v("ld w 0x04 new",  1, 0, 2'b10, 0, 32'h04, 32'h0,        32'h0BADF00D, 0));
    vecs.push_back(v("st w 0x100",     0, 1, 2'b10, 0, 32'h100,32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(v("ld w 0x00 wrap", 1, 0, 2'b10, 0, 32'h00, 32'h0,        32'hCAFEF00D, 0));

    rst_n = 1'b0;
    rd0 = 0; wr0 = 0; size0 = 2'b10; uns0 = 0; addr0 = '0; wd0 = '0;
    drive3(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    // Reset state: outputs forced low even with a request present.
    @(negedge clk);
    drive3(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    #1;
    chk("rst stall3", {31'b0, stall3}, 32'd0);
    chk("rst rdata3", rdata3, 32'd0);
    @(negedge clk);
    drive3(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst mis3", {31'b0, mis3}, 32'd0);
    idle3();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      rd0 = vecs[i].rd; wr0 = vecs[i].wr; size0 = vecs[i].size; uns0 = vecs[i].uns;
      addr0 = vecs[i].addr; wd0 = vecs[i].wdata;
      #1;
      chk({vecs[i].name, " rdata"}, rdata0, vecs[i].exp_rd);
      chk({vecs[i].name, " mis"},   {31'b0, mis0},   {31'b0, vecs[i].exp_mis});
      chk({vecs[i].name, " stall"}, {31'b0, stall0}, 32'd0);
    end
    @(negedge clk);
    rd0 = 0; wr0 = 0;

    acc3("l3 st 0x04",  1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h5A5A5A5A, 32'h0);
    idle3();
    acc3("l3 ld 0x04",  1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h5A5A5A5A);
    acc3("l3 st 0x10",  1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0);
    acc3("l3 ld 0x10",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h11223344);
    acc3("l3 ld hs 0x12", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,      32'h00001122);

    @(negedge clk);
    drive3(1'b1, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    #1;
    chk("l3 mis flag",  {31'b0, mis3},   32'd1);
    chk("l3 mis stall", {31'b0, stall3}, 32'd0);
    chk("l3 mis rdata", rdata3, 32'd0);
    idle3();

    // Abandoned store must leave memory untouched.
    acc3("l3 st 0x18",  1'b0, 1'b1, 2'b10, 1'b0, 32'h18, 32'h01020304, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive3(1'b0, 1'b1, 2'b10, 1'b0, 32'h18, 32'hFFFFFFFF);
      #1;
      chk($sformatf("l3 abandon stall c%0d", c), {31'b0, stall3}, 32'd1);
    end
    idle3();
    acc3("l3 ld 0x18",  1'b1, 1'b0, 2'b10, 1'b0, 32'h18, 32'h0,        32'h01020304);

    // Reset in the second stall cycle aborts the store.
    acc3("l3 st 0x14",  1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h55AA55AA, 32'h0);
    @(negedge clk);
    drive3(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
    #1;
    chk("l3 pre-rst stall", {31'b0, stall3}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("l3 rst stall", {31'b0, stall3}, 32'd0);
    chk("l3 rst mis",   {31'b0, mis3},   32'd0);
    chk("l3 rst rdata", rdata3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive3(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    #1;
    chk("l3 post-rst stall", {31'b0, stall3}, 32'd0);
    acc3("l3 ld 0x14",  1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h55AA55AA);
    acc3("l3 rd+wr",    1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0F0F0F0F, 32'h0);
    acc3("l3 ld 0x14b", 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h0F0F0F0F);
    idle3();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
